// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU593 between two clients.
// Single registered FSM: IDLE -> BUSY (ALU handshake, watchdog) -> RESP (done pulse).
module alu_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        c0_req,
    input  logic [7:0]  c0_a,
    input  logic [7:0]  c0_b,
    input  logic [3:0]  c0_op,
    output logic        c0_grant,
    output logic        c0_done,
    output logic [15:0] c0_result,
    output logic        c0_error,
    input  logic        c1_req,
    input  logic [7:0]  c1_a,
    input  logic [7:0]  c1_b,
    input  logic [3:0]  c1_op,
    output logic        c1_grant,
    output logic        c1_done,
    output logic [15:0] c1_result,
    output logic        c1_error,
    output logic        alu_start,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic              r_rr;
    logic              r_owner;
    logic [7:0]        r_cnt;
    logic [1:0]        r_grant;
    logic [1:0]        r_done;
    logic [1:0]        r_error;
    logic [1:0][15:0]  r_result;
    logic              r_start;
    logic [7:0]        r_a;
    logic [7:0]        r_b;
    logic [3:0]        r_op;
    logic              r_busy;

    // Lone requester wins outright; a tie goes to the round-robin pointer.
    logic w_win;
    assign w_win = (c0_req && c1_req) ? r_rr : c1_req;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_rr     <= 1'b0;
            r_owner  <= 1'b0;
            r_cnt    <= 8'd0;
            r_grant  <= 2'b00;
            r_done   <= 2'b00;
            r_error  <= 2'b00;
            r_result <= '0;
            r_start  <= 1'b0;
            r_a      <= 8'd0;
            r_b      <= 8'd0;
            r_op     <= 4'd0;
            r_busy   <= 1'b0;
        end else begin
            r_grant <= 2'b00;
            r_done  <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (c0_req || c1_req) begin
                        r_owner        <= w_win;
                        r_a            <= w_win ? c1_a  : c0_a;
                        r_b            <= w_win ? c1_b  : c0_b;
                        r_op           <= w_win ? c1_op : c0_op;
                        r_grant[w_win] <= 1'b1;
                        r_start        <= 1'b1;
                        r_busy         <= 1'b1;
                        r_cnt          <= 8'd0;
                        r_state        <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A completion on the watchdog edge still counts as normal.
                    if (alu_done) begin
                        r_result[r_owner] <= alu_result;
                        r_error[r_owner]  <= 1'b0;
                        r_done[r_owner]   <= 1'b1;
                        r_start           <= 1'b0;
                        r_state           <= S_RESP;
                    end else if (r_cnt == TMAX) begin
                        r_result[r_owner] <= 16'd0;
                        r_error[r_owner]  <= 1'b1;
                        r_done[r_owner]   <= 1'b1;
                        r_start           <= 1'b0;
                        r_state           <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_rr    <= ~r_owner;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign c0_grant  = r_grant[0];
    assign c1_grant  = r_grant[1];
    assign c0_done   = r_done[0];
    assign c1_done   = r_done[1];
    assign c0_result = r_result[0];
    assign c1_result = r_result[1];
    assign c0_error  = r_error[0];
    assign c1_error  = r_error[1];
    assign alu_start = r_start;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; watchdog shortened to 8 cycles.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        c0_req, c1_req;
    logic [7:0]  c0_a, c0_b, c1_a, c1_b;
    logic [3:0]  c0_op, c1_op;
    logic        c0_grant, c0_done, c0_error;
    logic        c1_grant, c1_done, c1_error;
    logic [15:0] c0_result, c1_result;
    logic        alu_start, alu_done, busy;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;

    int n_chk = 0;
    int n_err = 0;

    alu_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .c0_req(c0_req), .c0_a(c0_a), .c0_b(c0_b), .c0_op(c0_op),
        .c0_grant(c0_grant), .c0_done(c0_done), .c0_result(c0_result), .c0_error(c0_error),
        .c1_req(c1_req), .c1_a(c1_a), .c1_b(c1_b), .c1_op(c1_op),
        .c1_grant(c1_grant), .c1_done(c1_done), .c1_result(c1_result), .c1_error(c1_error),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n, d0, d1;
    logic exp_w;

    initial begin
        reset_n = 1'b0; c0_req = 0; c1_req = 0; alu_done = 0; alu_result = 16'h0;
        c0_a = 8'h12; c0_b = 8'h34; c0_op = 4'h1;
        c1_a = 8'hA5; c1_b = 8'h5A; c1_op = 4'h7;
        tick(); tick();
        chk("rst_outs", {c0_grant, c0_done, c0_error, c1_grant, c1_done, c1_error, alu_start, busy}, 0);
        chk("rst_res", {c0_result, c1_result}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
        reset_n = 1'b1;
        tick();

        // single client, alu_done sampled at edge T+4
        c0_req = 1;
        tick();
        chk("sc_grant", {c0_grant, c1_grant, alu_start, busy}, 4'b1011);
        chk("sc_opnd", {alu_a, alu_b, alu_op}, {8'h12, 8'h34, 4'h1});
        c0_req = 0;
        tick();
        chk("sc_grant_off", {c0_grant, alu_start}, 2'b01);
        tick(); tick();
        alu_done = 1; alu_result = 16'h0046;
        tick();
        chk("sc_done", {c0_done, c0_error, alu_start, busy}, 4'b1001);
        chk("sc_res", c0_result, 16'h0046);
        alu_done = 0;
        tick();
        chk("sc_idle", {c0_done, busy}, 0);
        chk("sc_c1", {c1_done, c1_error, c1_result}, 0);

        // reset in the middle of a c1 op; rr was 1 before reset
        c1_req = 1;
        tick();
        chk("rb_grant", {c0_grant, c1_grant, alu_start}, 3'b011);
        c1_req = 0;
        tick();
        reset_n = 0;
        tick();
        chk("rb_abort", {alu_start, busy, c0_done, c1_done}, 0);
        chk("rb_res", c0_result, 0);
        reset_n = 1;
        alu_done = 1; alu_result = 16'hBEEF;
        tick(); tick();
        chk("rb_ignore", {c0_done, c1_done, busy, alu_start}, 0);
        alu_done = 0;
        tick();

        // simultaneous requests: c0 first after reset
        c0_req = 1; c1_req = 1;
        tick();
        chk("sim_g0", {c0_grant, c1_grant}, 2'b10);
        chk("sim_a0", alu_a, 8'h12);
        c0_req = 0;
        alu_done = 1; alu_result = 16'h1111;
        tick();
        chk("sim_d0", {c0_done, c1_done}, 2'b10);
        alu_done = 0;
        tick();
        chk("sim_idle", {busy, c1_grant}, 0);
        tick();
        chk("sim_g1", {c0_grant, c1_grant}, 2'b01);
        chk("sim_op1", {alu_a, alu_b, alu_op}, {8'hA5, 8'h5A, 4'h7});
        c1_req = 0;
        alu_done = 1; alu_result = 16'h2222;
        tick();
        chk("sim_d1", {c1_done, c1_result}, {1'b1, 16'h2222});
        alu_done = 0;
        tick();

        // saturation fairness
        c0_req = 1; c1_req = 1;
        d0 = 0; d1 = 0;
        for (int i = 0; i < 6; i++) begin
            exp_w = i[0];
            tick();
            chk($sformatf("fair_g%0d", i), {c0_grant, c1_grant}, {~exp_w, exp_w});
            alu_done = 1; alu_result = 16'(16'h0100 + i);
            tick();
            if (c0_done) d0++;
            if (c1_done) d1++;
            alu_done = 0;
            tick();
        end
        chk("fair_d0", d0, 3);
        chk("fair_d1", d1, 3);
        chk("fair_res", {c0_result, c1_result}, {16'h0104, 16'h0105});
        c0_req = 0; c1_req = 0;
        tick();

        // timeout on c1
        c1_req = 1;
        tick();
        c1_req = 0;
        n = 0;
        while (alu_start && n < 20) begin
            n++;
            tick();
        end
        chk("to_start_cycles", n, 8);
        chk("to_done", {c1_done, c1_error, c1_result}, {1'b1, 1'b1, 16'h0});
        chk("to_c0_kept", {c0_error, c0_result}, {1'b0, 16'h0104});
        tick();
        c1_req = 1;
        tick();
        c1_req = 0;
        alu_done = 1; alu_result = 16'h1234;
        tick();
        chk("to_clear", {c1_done, c1_error, c1_result}, {1'b1, 1'b0, 16'h1234});
        alu_done = 0;
        tick();

        // alu_done on the watchdog edge completes normally
        c0_req = 1;
        tick();
        c0_req = 0;
        for (int i = 0; i < 7; i++) tick();
        chk("bnd_start", alu_start, 1);
        alu_done = 1; alu_result = 16'h0BAD;
        tick();
        chk("bnd_done", {c0_done, c0_error, c0_result}, {1'b1, 1'b0, 16'h0BAD});
        alu_done = 0;
        tick();

        // fastest completion
        c1_req = 1;
        tick();
        chk("fast_g", c1_grant, 1);
        c1_req = 0;
        alu_done = 1; alu_result = 16'h00FF;
        tick();
        chk("fast_done", {c1_done, c1_error, c1_result}, {1'b1, 1'b0, 16'h00FF});
        alu_done = 0;
        tick();
        chk("fast_idle", {busy, c1_done}, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU593 instance between two requesters, client 0 and client 1 (for example, two instruction units).
- Runs a round-robin arbiter and a clocked FSM. The FSM latches the winner's operands, drives the ALU start/done handshake, and routes the 16-bit result and a done pulse back to the winner.
- A watchdog aborts any operation whose alu_done never arrives.
- Sits between the instruction units and ALU593.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles in BUSY before abort. Legal range is 2 to 255.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- c0_req  input  1  client 0 request; hold high until c0_grant
- c0_a  input  8  client 0 operand A
- c0_b  input  8  client 0 operand B
- c0_op  input  4  client 0 ALU opcode (alu_opcode_t encoding)
- c0_grant  output  1  one-cycle pulse; operands captured
- c0_done  output  1  one-cycle pulse; c0_result/c0_error valid
- c0_result  output  16  client 0 result, held until its next done
- c0_error  output  1  set with c0_done on timeout; held like c0_result
- c1_req, c1_a, c1_b, c1_op, c1_grant, c1_done, c1_result, c1_error: identical set for client 1
- alu_start  output  1  ALU start, held until alu_done
- alu_a  output  8  operand A to ALU
- alu_b  output  8  operand B to ALU
- alu_op  output  4  opcode to ALU
- alu_done  input  1  ALU completion
- alu_result  input  16  ALU result, valid with alu_done
- busy  output  1  high in BUSY and RESP

Behaviour:
- All outputs are registered.
- Reset (reset_n low at a posedge):
  - state=IDLE, rr=0, timeout counter=0.
  - All outputs 0, including results, errors, alu_a/b/op and busy.
  - Reset mid-operation aborts at that edge: alu_start low next cycle, no done pulse. Any alu_done later seen in IDLE is ignored.
- States: IDLE, BUSY, RESP.
- IDLE:
  - If any req is high at the posedge, choose the winner w:
    - Only one req high: w is that client.
    - Both high: w = rr.
  - On that edge: latch w's a/b/op into alu_a/b/op, set owner=w, counter=0, go to BUSY.
  - In the first BUSY cycle: cw_grant=1 and alu_start=1.
  - A req dropped before it is sampled is lost; there is no queueing.
- BUSY:
  - alu_start stays 1 and alu_a/b/op stay stable. cN_grant is low after its first cycle.
  - Counter increments each cycle.
  - alu_done=1 at a posedge: latch alu_result into c_owner_result, clear c_owner_error, set alu_start=0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without alu_done: set alu_start=0, c_owner_result=0, c_owner_error=1, go to RESP.
  - alu_done and timeout on the same edge: alu_done wins and the result is normal.
- RESP (one cycle):
  - c_owner_done=1.
  - rr=~owner, so the other client has priority next.
  - Next state is IDLE.
  - Requests are not sampled in RESP. A req still high in the following IDLE is treated as a new request.
- Latency: req sampled at edge T, grant and alu_start during T+1. With alu_done sampled at edge T+k, done pulses during T+k+1 and IDLE returns at T+k+2. Minimum request-to-done is 2 cycles (alu_done at edge T+1).
- Results are per client: the non-owner's result/error are never modified.
- Opcode is forwarded unchanged; the arbiter does not decode it.
- busy = (state != IDLE).

Test Plan:
- Reset mid-BUSY: reset_n low while alu_start=1 -> next cycle alu_start=0, busy=0, no cN_done, rr=0. A later alu_done in IDLE produces no response.
- Single client: c0_req with a=8'h12, b=8'h34, add opcode, alu_done with 16'h0046 three cycles after start -> c0_grant during T+1, c0_done during T+5, c0_result=16'h0046, c0_error=0, c1 outputs unchanged.
- Simultaneous requests after reset: c0 and c1 both req -> c0 granted first. c1 is granted on the IDLE following c0's RESP, then rr=0.
- Fairness under saturation: both reqs held high for 6 operations -> grants alternate c0,c1,c0,c1,c0,c1. Both clients finish with exactly 3 done pulses each.
- Timeout: TIMEOUT_CYCLES=8, c1_req, alu_done never asserted -> alu_start high exactly 8 cycles, then c1_done with c1_error=1 and c1_result=0. The next c1 op completing normally clears c1_error.
- Boundary: alu_done on the same edge the counter reaches TIMEOUT_CYCLES-1 -> normal completion. Also, alu_done one edge after start (no_op) -> done during T+2.
